// File: rtl/lookup_ram_pipe.sv
// Single-port lookup RAM with a self-fill phase after reset and a LATENCY-deep read pipeline.
// Optional byte-enabled writes are compiled in with the LOOKUP_RAM_PIPE_BYTE_WR_EN macro.
module lookup_ram_pipe #(
    parameter int          ABITS       = 8,
    parameter int          DBITS       = 32,
    parameter int          LATENCY     = 1,
    parameter logic [63:0] INIT_VALUE  = 64'hBAD1BAD1BAD1BAD1,
    parameter logic [63:0] NOACT_VALUE = 64'hDEADBEEFDEADBEEF,
`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
    localparam int         BE_BITS     = DBITS / 8,
`else
    localparam int         BE_BITS     = 0,
`endif
    localparam int         W           = 1 + BE_BITS + ABITS + DBITS
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             TIE_lookup_ram_Out_Req,
    input  logic [W-1:0]     TIE_lookup_ram_Out,
    output logic             TIE_lookup_ram_Rdy,
    output logic [DBITS-1:0] TIE_lookup_ram_In,
    output logic             TIE_lookup_ram_In_Valid
);

    localparam int DEPTH = 1 << ABITS;

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [ABITS-1:0] r_fill_addr;
    logic [DBITS-1:0] r_mem [DEPTH];

    logic [LATENCY-1:0] r_vld;
    logic [DBITS-1:0]   r_pipe [LATENCY];

    logic               w_write;
    logic [ABITS-1:0]   w_addr;
    logic [DBITS-1:0]   w_data;
    logic               w_accept;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_fill_last;
    logic [DBITS-1:0]   w_idle_data;
    logic [LATENCY-1:0] w_stage_vld;
    logic [DBITS-1:0]   w_stage_dat [LATENCY];

    assign w_write  = TIE_lookup_ram_Out[W-1];
    assign w_addr   = TIE_lookup_ram_Out[DBITS +: ABITS];
    assign w_data   = TIE_lookup_ram_Out[DBITS-1:0];

    // Reset blocks acceptance even if the state register still says RUN this cycle.
    assign w_accept = TIE_lookup_ram_Out_Req && (r_state == ST_RUN) && !Reset;
    assign w_wr_acc = w_accept && w_write;
    assign w_rd_acc = w_accept && !w_write;

    assign w_fill_last = (r_state == ST_FILL) && (r_fill_addr == '1);
    assign w_idle_data = ((r_state == ST_RUN) || w_fill_last) ? NOACT_VALUE[DBITS-1:0]
                                                              : INIT_VALUE[DBITS-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_FILL;
            r_fill_addr <= '0;
        end else if (r_state == ST_FILL) begin
            r_fill_addr <= r_fill_addr + 1'b1;
            if (w_fill_last) begin
                r_state <= ST_RUN;
            end
        end
    end

    // NOTE: the memory array has no reset; the FILL phase initialises it one word per cycle instead.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (r_state == ST_FILL) begin
                r_mem[r_fill_addr] <= INIT_VALUE[DBITS-1:0];
            end else if (w_wr_acc) begin
`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
                for (int b = 0; b < BE_BITS; b++) begin
                    if (TIE_lookup_ram_Out[DBITS + ABITS + b]) begin
                        r_mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
`else
                r_mem[w_addr] <= w_data;
`endif
            end
        end
    end

    // Stage 0 captures the addressed word at the accept edge; later stages shift it along.
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        w_stage_vld    = '0;
        w_stage_vld[0] = w_rd_acc;
        w_stage_dat[0] = r_mem[w_addr];
        for (int i = 1; i < LATENCY; i++) begin
            w_stage_vld[i] = r_vld[i-1];
            w_stage_dat[i] = r_pipe[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_vld             <= '0;
            r_pipe[LATENCY-1] <= INIT_VALUE[DBITS-1:0];
        end else begin
            r_vld <= w_stage_vld;
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_pipe[i] <= w_stage_dat[i];
            end
            r_pipe[LATENCY-1] <= w_stage_vld[LATENCY-1] ? w_stage_dat[LATENCY-1] : w_idle_data;
        end
    end

    assign TIE_lookup_ram_Rdy      = (r_state == ST_RUN);
    assign TIE_lookup_ram_In       = r_pipe[LATENCY-1];
    assign TIE_lookup_ram_In_Valid = r_vld[LATENCY-1];

endmodule

// File: tb/tb_lookup_ram_pipe.sv
// Scoreboard bench for lookup_ram_pipe: a cycle-level memory model queues expected reads,
// and an independent monitor compares every output cycle against it.
module tb_lookup_ram_pipe;

    localparam int ABITS   = 8;
    localparam int DBITS   = 32;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 1 << ABITS;
`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
    localparam int BEW = DBITS / 8;
`else
    localparam int BEW = 0;
`endif
    localparam int W = 1 + BEW + ABITS + DBITS;

    localparam logic [31:0] INIT  = 32'hBAD1BAD1;
    localparam logic [31:0] NOACT = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [W-1:0]     out_bus;
    logic             rdy;
    logic [DBITS-1:0] in_data;
    logic             in_valid;

    logic             d_write = 1'b0;
    logic [7:0]       d_addr = '0;
    logic [31:0]      d_data = '0;
    logic [3:0]       d_be = 4'hF;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always_comb begin
`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
        out_bus = {d_write, d_be, d_addr, d_data};
`else
        out_bus = {d_write, d_addr, d_data};
`endif
    end

    lookup_ram_pipe #(
        .ABITS   (ABITS),
        .DBITS   (DBITS),
        .LATENCY (LATENCY)
    ) dut (
        .CLK                     (clk),
        .Reset                   (reset),
        .TIE_lookup_ram_Out_Req  (req),
        .TIE_lookup_ram_Out      (out_bus),
        .TIE_lookup_ram_Rdy      (rdy),
        .TIE_lookup_ram_In       (in_data),
        .TIE_lookup_ram_In_Valid (in_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a word array, a "cycles left in fill" count and a queue of due reads.
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic [31:0] m_mem [DEPTH];
    bit          m_run = 1'b0;
    int          m_fill_left = 0;
    exp_t        q[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_run       = 1'b0;
            m_fill_left = DEPTH;
            q.delete();
            foreach (m_mem[i]) m_mem[i] = INIT;
        end else if (!m_run) begin
            m_fill_left--;
            if (m_fill_left == 0) m_run = 1'b1;
        end else if (req) begin
            if (d_write) begin
`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) m_mem[d_addr][8*b +: 8] = d_data[8*b +: 8];
`else
                m_mem[d_addr] = d_data;
`endif
            end else begin
                q.push_back('{data: m_mem[d_addr], due: cyc + LATENCY - 1});
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("rdy", rdy, m_run);
            if (in_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", in_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rd_data", in_data, e.data);
                    check("rd_cycle", cyc, e.due);
                end
            end else begin
                check("idle_data", in_data, m_run ? NOACT : INIT);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    check("missing_valid", in_valid, 1'b1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
        req     = 1'b1;
        d_write = w;
        d_addr  = 8'(a);
        d_data  = d;
        d_be    = be;
        step();
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (rdy !== 1'b1 && k < 1000) begin
            step();
            k++;
        end
        if (k >= 1000) check("ready_timeout", rdy, 1'b1);
    endtask

    initial begin
        // Reset with a write to 0x20 held through reset and most of FILL; it must not land.
        reset = 1'b1;
        drive(1, 'h20, 32'h55555555, 4'hF);
        step();
        step();
        reset = 1'b0;
        repeat (200) step();
        idle(1);
        wait_ready();

        drive(0, 'h7F, '0, 4'hF);
        drive(0, 'h20, '0, 4'hF);
        idle(2);

        // Write then read the same address on the next cycle.
        drive(1, 'h05, 32'h12345678, 4'hF);
        drive(0, 'h05, '0, 4'hF);
        idle(5);

        drive(1, 'h01, 32'hA1, 4'hF);
        drive(1, 'h02, 32'hA2, 4'hF);
        drive(1, 'h03, 32'hA3, 4'hF);
        drive(0, 'h01, '0, 4'hF);
        drive(0, 'h02, '0, 4'hF);
        drive(0, 'h03, '0, 4'hF);
        idle(5);

        // A read in flight keeps the old value when a write to the same address follows.
        drive(0, 'h05, '0, 4'hF);
        drive(1, 'h05, 32'hCAFEF00D, 4'hF);
        drive(0, 'h05, '0, 4'hF);
        idle(5);

        drive(1, 'h00, 32'h00000001, 4'hF);
        drive(1, 'hFF, 32'hFFFFFFFE, 4'hF);
        drive(0, 'h00, '0, 4'hF);
        drive(0, 'hFF, '0, 4'hF);
        idle(5);

`ifdef LOOKUP_RAM_PIPE_BYTE_WR_EN
        drive(1, 'h10, 32'hFFFFFFFF, 4'b0101);
        drive(0, 'h10, '0, 4'hF);
        drive(1, 'h11, 32'h12345678, 4'b0000);
        drive(0, 'h11, '0, 4'hF);
        idle(5);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                drive($urandom_range(0, 1),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1),
                      $urandom, 4'($urandom));
            end
        end
        idle(6);

        // Reset again when the fill pointer has reached address 100.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (100) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready();
        drive(0, 'h7F, '0, 4'hF);
        idle(6);

        // Reset one cycle after a read accept: the read must never surface.
        drive(0, 'h7F, '0, 4'hF);
        req   = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(LATENCY + 3);
        wait_ready();
        drive(0, 'h05, '0, 4'hF);
        drive(0, 'h01, '0, 4'hF);
        idle(6);

        check("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lookup_ram_pipe.md
LOOKUP_RAM_PIPE -- requirements
Module: lookup_ram_pipe

Interface
REQ-001 The module SHALL declare parameter ABITS, default 8, meaning the address width, with depth 2^ABITS words and a legal range of 2..12.
REQ-002 The module SHALL declare parameter DBITS, default 32, meaning the data width, with a legal range of 8..64 in multiples of 8.
REQ-003 The module SHALL declare parameter LATENCY, default 1, meaning the number of cycles from request accept to read data on TIE_lookup_ram_In, with a legal range of 1..4.
REQ-004 The module SHALL declare parameter INIT_VALUE, default 64'hBAD1BAD1BAD1BAD1, meaning the memory fill pattern and the reset value of the read data; only the low DBITS bits are used.
REQ-005 The module SHALL declare parameter NOACT_VALUE, default 64'hDEADBEEFDEADBEEF, meaning the read data driven in idle cycles; only the low DBITS bits are used.
REQ-006 Port CLK SHALL be an input, 1 bit wide: the only clock, with all logic on its rising edge.
REQ-007 Port Reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-008 Port TIE_lookup_ram_Out_Req SHALL be an input, 1 bit wide: request strobe.
REQ-009 Port TIE_lookup_ram_Out SHALL be an input, W bits wide, packed as {write, address[ABITS-1:0], data[DBITS-1:0]}, where W = 1+ABITS+DBITS (BE field per REQ-030).
REQ-010 Port TIE_lookup_ram_Rdy SHALL be an output, 1 bit wide: the block accepts a request this cycle.
REQ-011 Port TIE_lookup_ram_In SHALL be an output, DBITS bits wide: read data.
REQ-012 Port TIE_lookup_ram_In_Valid SHALL be an output, 1 bit wide: TIE_lookup_ram_In carries read data this cycle.

Function
REQ-013 A request SHALL be accepted on a rising edge only when Out_Req=1 and Rdy=1; a request with Rdy=0 is ignored and the requester holds it.
REQ-014 The control state machine SHALL have exactly two states, FILL and RUN; Rdy SHALL be 0 in FILL and 1 in RUN.
REQ-015 In FILL, the block SHALL write INIT_VALUE to one address per cycle, ascending from 0 to 2^ABITS-1, and move to RUN on the cycle after writing the last address (FILL lasts 2^ABITS cycles).
REQ-016 An accepted write SHALL update mem[address] at the accept edge and launch no read data.
REQ-017 An accepted read SHALL sample mem[address] at the accept edge and present it on In with In_Valid=1 exactly LATENCY cycles after accept.
REQ-018 Read-after-write ordering: a read accepted on the cycle after a write to the same address SHALL return the new data.
REQ-019 Back-to-back reads SHALL sustain one per cycle, with each result in its own cycle and in issue order.
REQ-020 In any cycle where the output pipeline stage holds no read, In SHALL equal NOACT_VALUE and In_Valid SHALL be 0.
REQ-021 Addresses SHALL use the full ABITS range; there is no wrap or aliasing beyond the encoded address.
REQ-022 Read results already in the pipeline when a later write to the same address arrives SHALL keep their sampled (old) value.

Reset
REQ-023 While Reset=1 at a rising edge, the state SHALL go to FILL, the fill address SHALL go to 0, all pipeline valid bits SHALL clear, In SHALL become INIT_VALUE[DBITS-1:0], In_Valid SHALL become 0, and Rdy SHALL become 0.
REQ-024 Reset asserted mid-FILL or mid-RUN SHALL restart FILL from address 0 and discard all in-flight reads; no stale In_Valid pulse SHALL appear afterwards.
REQ-025 In SHALL hold INIT_VALUE from reset until the first post-reset cycle in RUN, then follow REQ-020.
REQ-026 Requests presented during Reset or FILL SHALL have no effect on memory contents.

Configuration
REQ-027 The block SHALL support the macro LOOKUP_RAM_PIPE_BYTE_WR_EN, which compiles byte-enabled writes in or out.
REQ-028 With LOOKUP_RAM_PIPE_BYTE_WR_EN defined, TIE_lookup_ram_Out SHALL be {write, be[DBITS/8-1:0], address, data}.
REQ-029 With the macro defined, an accepted write SHALL update only the bytes whose be bit is 1; be=0 SHALL leave the word unchanged.
REQ-030 With the macro undefined, the be field SHALL be absent, W = 1+ABITS+DBITS, and writes SHALL be full-word.
REQ-031 The macro SHALL NOT affect reads, FILL, latency, or reset behaviour.

Verification
REQ-032 Scenario: ABITS=8, Reset pulsed for 1 cycle -> Rdy=0 for 256 cycles and then 1; a read of address 0x7F then returns 0xBAD1BAD1 after LATENCY cycles.
REQ-033 Scenario: LATENCY=3, write 0x12345678 to 0x05, then read 0x05 on the next cycle -> In=0x12345678 and In_Valid=1 exactly 3 cycles after the read accept; In=0xDEADBEEF in the other cycles.
REQ-034 Scenario: reads of 0x01, 0x02, 0x03 on consecutive cycles after writing 0xA1, 0xA2, 0xA3 to them -> In shows 0xA1, 0xA2, 0xA3 on 3 consecutive cycles.
REQ-035 Scenario: Reset asserted at FILL address 100, and again 1 cycle after a read accept with LATENCY=2 -> FILL restarts from address 0, no In_Valid pulse occurs, and In=0xBAD1BAD1.
REQ-036 Scenario: with LOOKUP_RAM_PIPE_BYTE_WR_EN defined, DBITS=32, write 0xFFFFFFFF with be=4'b0101 to 0x10 after FILL -> a read of 0x10 returns 0xBAFFBAFF.
REQ-037 Scenario: Out_Req=1 with a write to 0x20 during FILL -> after FILL, a read of 0x20 returns 0xBAD1BAD1.
